crc16_frame_checker: RTL and testbench

// - Receive-side checker for the CRC16 word-stream generator.
// - Accepts a frame of 16-bit data words followed by one CRC trailer word over a valid/ready stream.
// - Recomputes the CRC over the data words, compares it with the trailer and reports pass/fail per frame.
// - Keeps saturating pass/fail frame counters for the fault-sweep harness.

---
 rtl/crc16_frame_checker.sv | 133 +++++++++++++
 tb/tb_crc16_frame_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC16 frame checker: recomputes the CRC over a valid/ready word stream,
// compares it with the trailer word, and keeps saturating pass/fail counters.
// Optional build macro CRC16_CHK_FAULT_EN adds fault_mask/fault_value injection ports.
module crc16_frame_checker #(
  parameter logic [15:0] POLY      = 16'h1021,
  parameter logic [15:0] INIT      = 16'hFFFF,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
`ifdef CRC16_CHK_FAULT_EN
  input  logic [15:0]      fault_mask,
  input  logic [15:0]      fault_value,
`endif
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_len_err,
  output logic [15:0]      crc_calc,
  output logic [15:0]      crc_rx,
  output logic [15:0]      frame_words,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

  localparam logic [15:0] MAXW = MAX_WORDS[15:0];

  state_t             r_state, w_next;
  logic [15:0]        r_crc, r_cnt, r_crc_calc, r_crc_rx, r_frame_words;
  logic               r_len_err, r_res_ok, r_res_len_err;
  logic [CNT_W-1:0]   r_cnt_ok, r_cnt_bad;
  logic [15:0]        w_data, w_crc_upd;
  logic               w_acc, w_ok;

  // Bit 0 first, sixteen serial LFSR steps collapsed into one cycle.
  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 16; i++) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return c;
  endfunction

`ifdef CRC16_CHK_FAULT_EN
  assign w_data = (s_data & ~fault_mask) | (fault_value & fault_mask);
`else
  assign w_data = s_data;
`endif

  assign w_acc     = s_valid && s_ready;
  assign w_crc_upd = crc_step(r_crc, w_data);
  assign w_ok      = (r_crc == w_data) && !r_len_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = s_last ? RESULT : RUN;
      RUN:     if (w_acc) w_next = s_last ? RESULT : ((r_cnt == MAXW) ? DRAIN : RUN);
      DRAIN:   if (w_acc && s_last) w_next = RESULT;
      RESULT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // reset_n gates s_ready so the source sees no room while reset is held.
  always_comb begin
    s_ready   = reset_n && (r_state != RESULT);
    res_valid = (r_state == RESULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc         <= INIT;
      r_cnt         <= '0;
      r_len_err     <= 1'b0;
      r_crc_calc    <= '0;
      r_crc_rx      <= '0;
      r_frame_words <= '0;
      r_res_ok      <= 1'b0;
      r_res_len_err <= 1'b0;
      r_cnt_ok      <= '0;
      r_cnt_bad     <= '0;
    end else if (r_state == RESULT) begin
      r_crc     <= INIT;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (w_acc) begin
      if (s_last) begin
        // Result fields and counters land together so they are stable while res_valid is high.
        r_crc_rx      <= w_data;
        r_crc_calc    <= r_crc;
        r_frame_words <= r_cnt;
        r_res_ok      <= w_ok;
        r_res_len_err <= r_len_err;
        if (w_ok) begin
          if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
        end else begin
          if (r_cnt_bad != '1) r_cnt_bad <= r_cnt_bad + CNT_W'(1);
        end
      end else if (r_state != DRAIN) begin
        if (r_cnt == MAXW) begin
          r_len_err <= 1'b1;
        end else begin
          r_crc <= w_crc_upd;
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign res_ok      = r_res_ok;
  assign res_len_err = r_res_len_err;
  assign crc_calc    = r_crc_calc;
  assign crc_rx      = r_crc_rx;
  assign frame_words = r_frame_words;
  assign cnt_ok      = r_cnt_ok;
  assign cnt_bad     = r_cnt_bad;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: the driver pushes the expected result of each
// frame, and a monitor pops and compares on every res_valid pulse.
module tb_crc16_frame_checker;
  localparam int MW = 4;
  localparam int CW = 3;

  typedef logic [15:0] wq_t[$];
  typedef struct {
    logic          ok, le;
    logic [15:0]   calc, rx, words;
    logic [CW-1:0] cok, cbad;
  } exp_t;

  logic          clk = 1'b0, reset_n = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [15:0]   s_data = 16'h0;
  logic          s_ready, res_valid, res_ok, res_len_err;
  logic [15:0]   crc_calc, crc_rx, frame_words;
  logic [CW-1:0] cnt_ok, cnt_bad;
  logic [15:0]   m_mask = 16'h0, m_val = 16'h0;

  always #5 clk = ~clk;

  crc16_frame_checker #(.MAX_WORDS(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
`ifdef CRC16_CHK_FAULT_EN
    .fault_mask(m_mask), .fault_value(m_val),
`endif
    .res_valid(res_valid), .res_ok(res_ok), .res_len_err(res_len_err),
    .crc_calc(crc_calc), .crc_rx(crc_rx), .frame_words(frame_words),
    .cnt_ok(cnt_ok), .cnt_bad(cnt_bad)
  );

  exp_t q[$];
  exp_t last_e;
  int   total = 0, bad = 0, n_res = 0, n_rdy_low = 0, m_ok = 0, m_bad = 0;
  bit   pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC straight from the definition: each word's bits fed LSB first into a shift-left LFSR.
  function automatic logic [15:0] crc_of(input wq_t w, input int n);
    int c = 'hFFFF;
    for (int k = 0; k < n; k++) begin
      int wd = int'(w[k]);
      for (int i = 0; i < 16; i++) begin
        int fb = ((wd >> i) & 1) ^ ((c >> 15) & 1);
        c = ((c << 1) & 'hFFFF) ^ (fb != 0 ? 'h1021 : 0);
      end
    end
    return 16'(c);
  endfunction

  function automatic logic [15:0] inj(input logic [15:0] d);
    return (d & ~m_mask) | (m_val & m_mask);
  endfunction

  task automatic put(input logic [15:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL put_timeout: s_ready stayed %0b, expected 1", s_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_data = 16'($urandom); s_last = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send(input wq_t w, input logic [15:0] tr);
    exp_t e;
    wq_t  wf;
    int   n = w.size();
    foreach (w[k]) wf.push_back(inj(w[k]));
    e.le    = (n > MW);
    e.words = 16'(e.le ? MW : n);
    e.calc  = crc_of(wf, e.le ? MW : n);
    e.rx    = inj(tr);
    e.ok    = !e.le && (e.calc == e.rx);
    if (e.ok) m_ok  = (m_ok  < 7) ? m_ok + 1  : 7;
    else      m_bad = (m_bad < 7) ? m_bad + 1 : 7;
    e.cok  = CW'(m_ok);
    e.cbad = CW'(m_bad);
    q.push_back(e);
    foreach (w[k]) put(w[k], 1'b0);
    put(tr, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset_n) pend = 1'b0;
    else begin
      if (pend) begin
        chk("cnt_ok", 32'(cnt_ok), 32'(last_e.cok));
        chk("cnt_bad", 32'(cnt_bad), 32'(last_e.cbad));
        pend = 1'b0;
      end
      if (!s_ready) n_rdy_low++;
      if (res_valid) begin
        n_res++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_res_valid: got 1 expected 0");
        end else begin
          last_e = q.pop_front();
          chk("res_ok", 32'(res_ok), 32'(last_e.ok));
          chk("res_len_err", 32'(res_len_err), 32'(last_e.le));
          chk("crc_calc", 32'(crc_calc), 32'(last_e.calc));
          chk("crc_rx", 32'(crc_rx), 32'(last_e.rx));
          chk("frame_words", 32'(frame_words), 32'(last_e.words));
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    wq_t w;
    logic [15:0] tr;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_cnt_ok", 32'(cnt_ok), 0);
    chk("rst_crc_calc", 32'(crc_calc), 0);
    chk("rst_frame_words", 32'(frame_words), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 1);

    w = {};                 send(w, 16'hFFFF); idle(2);
    w = {16'h0000};         send(w, 16'h1D0F); idle(1);
    w = {16'h0000};         send(w, 16'h1D0E); idle(1);

    // Back-to-back 4-word frames with s_valid held high across frames.
    for (int f = 0; f < 3; f++) begin
      w = {};
      for (int k = 0; k < 4; k++) w.push_back(16'($urandom));
      send(w, crc_of(w, 4));
    end
    idle(2);

    w = {};
    for (int k = 0; k < 6; k++) w.push_back(16'($urandom));
    send(w, crc_of(w, 6));
    idle(2);

    // Reset mid-frame: partial frame must vanish without a result.
    put(16'h1234, 1'b0);
    put(16'h5678, 1'b0);
    s_valid = 1'b0;
    reset_n = 1'b0;
    m_ok = 0; m_bad = 0;
    @(negedge clk);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_cnt_ok", 32'(cnt_ok), 0);
    reset_n = 1'b1;
    idle(3);
    w = {16'hA5A5, 16'h0F0F};
    send(w, crc_of(w, 2));
    idle(2);

    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(0, 6);
      w = {};
      for (int k = 0; k < n; k++) w.push_back(16'($urandom));
      tr = ($urandom_range(0, 3) != 0) ? crc_of(w, n) : 16'($urandom);
      send(w, tr);
      idle($urandom_range(0, 2));
    end

`ifdef CRC16_CHK_FAULT_EN
    w = {16'h0003, 16'h1111};
    tr = crc_of(w, 2);
    m_mask = 16'h0001; m_val = 16'h0000;
    send(w, tr); idle(2);
    m_mask = 16'h0000;
    send(w, tr); idle(2);
`endif

    idle(4);
    chk("queue_empty", 32'(q.size()), 0);
    chk("ready_low_per_frame", 32'(n_rdy_low), 32'(n_res));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1);
  end
endmodule
